// File: rtl/multiplier_wallace_8x8.sv
// Unsigned 8x8 -> 16 multiplier: Wallace-tree partial-product reduction plus ripple final adder.
// Latency 1 cycle (single output register); throughput one product per cycle.
// No backpressure: operands qualified by in_valid are accepted every cycle.
module multiplier_wallace_8x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        in_valid,
    output logic [15:0] product,
    output logic        out_valid
);

    // 3:2 compressor, returns {carry, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    // 2:2 compressor, returns {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Builds the 64 partial-product bits into weight columns and compresses
    // them in four parallel stages (max height 8 -> 6 -> 4 -> 3 -> 2).
    // Column heights depend only on loop constants, so the loops unroll into
    // a fixed adder tree. Returns {row1, row0}.
    function automatic logic [31:0] wallace_rows(input logic [7:0] x, input logic [7:0] y);
        logic [7:0]  col [16];
        logic [7:0]  nxt [16];
        int          h   [16];
        int          hn  [16];
        logic [1:0]  cs;
        logic [15:0] r0;
        logic [15:0] r1;
        int          k;
        for (int w = 0; w < 16; w++) begin
            col[w] = '0;
            h[w]   = 0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col[i+j][h[i+j]] = x[j] & y[i];
                h[i+j] = h[i+j] + 1;
            end
        end
        for (int st = 0; st < 4; st++) begin
            for (int w = 0; w < 16; w++) begin
                nxt[w] = '0;
                hn[w]  = 0;
            end
            for (int w = 0; w < 16; w++) begin
                k = 0;
                // Full adders consume groups of three bits
                while (h[w] - k >= 3) begin
                    cs = full_add(col[w][k], col[w][k+1], col[w][k+2]);
                    nxt[w][hn[w]] = cs[0];
                    hn[w] = hn[w] + 1;
                    if (w < 15) begin
                        nxt[w+1][hn[w+1]] = cs[1];
                        hn[w+1] = hn[w+1] + 1;
                    end
                    k = k + 3;
                end
                // A leftover pair goes through a half adder, a single bit passes through
                if (h[w] - k == 2) begin
                    cs = half_add(col[w][k], col[w][k+1]);
                    nxt[w][hn[w]] = cs[0];
                    hn[w] = hn[w] + 1;
                    if (w < 15) begin
                        nxt[w+1][hn[w+1]] = cs[1];
                        hn[w+1] = hn[w+1] + 1;
                    end
                end else if (h[w] - k == 1) begin
                    nxt[w][hn[w]] = col[w][k];
                    hn[w] = hn[w] + 1;
                end
            end
            for (int w = 0; w < 16; w++) begin
                col[w] = nxt[w];
                h[w]   = hn[w];
            end
        end
        for (int w = 0; w < 16; w++) begin
            r0[w] = (h[w] > 0) ? col[w][0] : 1'b0;
            r1[w] = (h[w] > 1) ? col[w][1] : 1'b0;
        end
        return {r1, r0};
    endfunction

    logic [31:0] rows;
    logic [15:0] sum;

    // Reduction tree followed by a ripple carry-propagate adder; the carry out of bit 15 is always zero
    always_comb begin
        logic       carry;
        logic [1:0] cs;
        rows  = wallace_rows(a, b);
        sum   = '0;
        carry = 1'b0;
        for (int w = 0; w < 16; w++) begin
            cs     = full_add(rows[w], rows[16+w], carry);
            sum[w] = cs[0];
            carry  = cs[1];
        end
    end

    // Output register: clears on reset, loads only qualified operands, otherwise holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            product   <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                product <= sum;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_wallace_8x8.sv
module tb_multiplier_wallace_8x8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_valid;
    logic [15:0] product;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    // Reference state: what the output register should hold
    logic [15:0] exp_p;
    logic        exp_v;

    multiplier_wallace_8x8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .product   (product),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance past the edge and update the reference
    task automatic apply(input logic [7:0] ta, input logic [7:0] tb, input logic tv, input logic tr);
        a        = ta;
        b        = tb;
        in_valid = tv;
        rst_n    = tr;
        @(posedge clk);
        #1;
        if (!tr) begin
            exp_p = 16'd0;
            exp_v = 1'b0;
        end else begin
            exp_v = tv;
            if (tv) exp_p = 16'(int'(ta) * int'(tb));
        end
    endtask

    task automatic check(input string tag);
        total++;
        assert (product === exp_p) else begin
            bad++;
            $error("FAIL %s product got=%0d want=%0d", tag, product, exp_p);
        end
        total++;
        assert (out_valid === exp_v) else begin
            bad++;
            $error("FAIL %s out_valid got=%0b want=%0b", tag, out_valid, exp_v);
        end
    endtask

    initial begin
        logic [7:0] va [8];
        logic [7:0] vb [8];
        int         bad_before;
        va = '{8'd0, 8'd5, 8'd10, 8'd25, 8'd55, 8'd100, 8'd255, 8'd255};
        vb = '{8'd0, 8'd7, 8'd14, 8'd3,  8'd22, 8'd12,  8'd1,   8'd255};
        exp_p = 16'd0;
        exp_v = 1'b0;

        // Reset held two cycles with live operands
        apply(8'd255, 8'd255, 1'b1, 1'b0);
        check("reset_c1");
        apply(8'd255, 8'd255, 1'b1, 1'b0);
        check("reset_c2");
        if (product !== 16'd0) begin
            bad++;
            total++;
            $error("FAIL reset_zero product got=%0d want=0", product);
        end else total++;
        apply(8'd255, 8'd255, 1'b1, 1'b1);
        check("release_255x255");
        if (product !== 16'd65025) begin
            bad++;
            $error("FAIL release_literal product got=%0d want=65025", product);
        end
        total++;

        // Directed vectors, one per cycle
        for (int i = 0; i < 8; i++) begin
            apply(va[i], vb[i], 1'b1, 1'b1);
            check($sformatf("directed_%0dx%0d", va[i], vb[i]));
        end

        // Hold: drop in_valid after 5x7
        apply(8'd5, 8'd7, 1'b1, 1'b1);
        check("hold_load_5x7");
        apply(8'd9, 8'd9, 1'b0, 1'b1);
        check("hold_idle_1");
        apply(8'd9, 8'd9, 1'b0, 1'b1);
        check("hold_idle_2");
        if (product !== 16'd35) begin
            bad++;
            $error("FAIL hold_value product got=%0d want=35", product);
        end
        total++;

        // Column stress patterns
        apply(8'hAA, 8'h55, 1'b1, 1'b1);
        check("stress_AAx55");
        apply(8'hFF, 8'h80, 1'b1, 1'b1);
        check("stress_FFx80");

        // Back-to-back random stream, stopping at the first mismatch
        bad_before = bad;
        for (int i = 0; i < 2000; i++) begin
            apply(8'($urandom), 8'($urandom), 1'b1, 1'b1);
            check("stream");
            if (bad != bad_before) break;
        end

        // Mid-stream reset on the third operand
        apply(8'd12, 8'd13, 1'b1, 1'b1);
        check("mid_op1");
        apply(8'd200, 8'd3, 1'b1, 1'b1);
        check("mid_op2");
        apply(8'd77, 8'd77, 1'b1, 1'b0);
        check("mid_reset");
        apply(8'd201, 8'd99, 1'b1, 1'b1);
        check("mid_after_release");

        // Random valid gaps
        for (int i = 0; i < 200; i++) begin
            apply(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            check("gapped");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
